// File: rtl/demux_1to2_buffered.sv
// One producer stream steered to two consumers, each behind its own small FIFO,
// so a stalled consumer never blocks traffic headed for the other one.
module demux_1to2_buffered #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_sel,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [WIDTH-1:0]         out0_data,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [WIDTH-1:0]         out1_data,
  output logic [$clog2(DEPTH):0]   out0_count,
  output logic [$clog2(DEPTH):0]   out1_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             full     [2];
  logic             not_empty[2];
  logic             pop_req  [2];
  logic [WIDTH-1:0] head     [2];
  logic [CW-1:0]    count    [2];

  // Ready looks only at the selected FIFO's fill level, never at consumer ready.
  assign in_ready   = in_sel ? !full[1] : !full[0];

  assign pop_req[0] = out0_ready;
  assign pop_req[1] = out1_ready;

  assign out0_valid = not_empty[0];
  assign out1_valid = not_empty[1];
  assign out0_data  = head[0];
  assign out1_data  = head[1];
  assign out0_count = count[0];
  assign out1_count = count[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WIDTH-1:0] mem_reg [DEPTH];
      logic [AW-1:0]    wr_ptr_reg;
      logic [AW-1:0]    rd_ptr_reg;
      logic [CW-1:0]    count_reg;
      logic             push;
      logic             pop;

      assign full[gi]      = (count_reg == CW'(DEPTH));
      assign not_empty[gi] = (count_reg != '0);
      // A full FIFO refuses the push even if it is being popped this cycle.
      assign push          = in_valid && (in_sel == 1'(gi)) && !full[gi];
      assign pop           = not_empty[gi] && pop_req[gi];
      assign head[gi]      = mem_reg[rd_ptr_reg];
      assign count[gi]     = count_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
          end
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) begin
            mem_reg[wr_ptr_reg] <= in_data;
            wr_ptr_reg          <= wr_ptr_reg + AW'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
          end
          case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_demux_1to2_buffered.sv
// Directed scoreboard bench for demux_1to2_buffered: accepted pushes queue the
// expected word; a negedge monitor compares every pop against the queue head.
module tb_demux_1to2_buffered;

  localparam int WIDTH = 64;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [1:0]       out0_count;
  logic [1:0]       out1_count;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  demux_1to2_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every pop the DUT performs must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL out0_pop unexpected word actual=%h required=none", out0_data);
        end else begin
          chk("out0_pop", out0_data, q0.pop_front());
        end
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL out1_pop unexpected word actual=%h required=none", out1_data);
        end else begin
          chk("out1_pop", out1_data, q1.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  // Move to the sampling point of the current cycle and log an accepted push.
  task automatic sample();
    @(negedge clk);
    if (in_valid && in_ready) begin
      if (in_sel) q1.push_back(in_data);
      else        q0.push_back(in_data);
      $display("push sel=%0d data=%h", in_sel, in_data);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                      input logic r0, input logic r1);
    drive(v, sel, d, r0, r1);
    sample();
    advance();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] wv;
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1. idle after reset
    sample();
    chk("rst_in_ready",   in_ready,   1);
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_data",  out0_data,  0);
    chk("rst_out1_data",  out1_data,  0);
    chk("rst_out0_count", out0_count, 0);
    chk("rst_out1_count", out1_count, 0);
    advance();

    // 2. single push to out0, visible one cycle later
    step(1'b1, 1'b0, 64'h0000000000000005, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    sample();
    chk("t2_out0_valid", out0_valid, 1);
    chk("t2_out0_data",  out0_data,  64'h5);
    chk("t2_out0_count", out0_count, 1);
    chk("t2_out1_valid", out1_valid, 0);
    advance();
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    sample();
    chk("t2_drain_count", out0_count, 0);
    advance();

    // 3. fill out1 with consumer stalled
    step(1'b1, 1'b1, 64'hAAAAAAAAAAAAAAAA, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
    sample();
    chk("t3_out1_count",   out1_count, 2);
    chk("t3_ready_sel1",   in_ready,   0);
    chk("t3_out1_data_hd", out1_data,  64'hAAAAAAAAAAAAAAAA);
    advance();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    sample();
    chk("t3_ready_sel0",   in_ready,   1);
    chk("t3_out1_stable",  out1_data,  64'hAAAAAAAAAAAAAAAA);
    advance();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    sample();
    chk("t3_drain_count", out1_count, 0);
    advance();

    // 4. full out0: push refused on first pop cycle, then push+pop keeps count
    step(1'b1, 1'b0, 64'h11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 64'h22, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 64'h33, 1'b1, 1'b0);
    sample();
    chk("t4_full_ready", in_ready,   0);
    chk("t4_full_count", out0_count, 2);
    advance();
    sample();
    chk("t4_pop_count", out0_count, 1);
    chk("t4_pop_ready", in_ready,   1);
    advance();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    sample();
    chk("t4_pushpop_count", out0_count, 1);
    advance();
    sample();
    chk("t4_drain_count", out0_count, 0);
    advance();

    // 5. overlapped push/pop across pointer wrap
    for (int i = 0; i < 5; i++) begin
      wv = (i % 2 == 0) ? 64'h123456789ABCDEF0 : 64'hFEDCBA9876543210;
      step(1'b1, 1'b0, wv, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    sample();
    chk("t5_count_mid", out0_count, 1);
    advance();
    sample();
    chk("t5_count_end", out0_count, 0);
    advance();

    // 6. asynchronous reset with words buffered
    step(1'b1, 1'b0, 64'hA0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 64'hA1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'hB0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    sample();
    chk("t6_pre_count0", out0_count, 2);
    chk("t6_pre_count1", out1_count, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_count0", out0_count, 0);
    chk("t6_async_count1", out1_count, 0);
    chk("t6_async_valid0", out0_valid, 0);
    chk("t6_async_valid1", out1_valid, 0);
    chk("t6_async_ready",  in_ready,   1);
    q0.delete();
    q1.delete();
    advance();
    reset = 1'b0;
    step(1'b1, 1'b1, 64'h5, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    sample();
    chk("t6_out1_valid", out1_valid, 1);
    chk("t6_out1_data",  out1_data,  64'h5);
    chk("t6_out1_count", out1_count, 1);
    chk("t6_out0_valid", out0_valid, 0);
    chk("t6_out0_count", out0_count, 0);
    advance();
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    chk("end_q0_empty", 64'(q0.size()), 0);
    chk("end_q1_empty", 64'(q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
